// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master moving one word per valid/ready handshake.
// Chip select stays low across words until a word flagged last completes.
module spi_master #(
    parameter int K_DWIDTH = 16,
    parameter int K_CLKDIV = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [K_DWIDTH-1:0] i_data,
    input  logic                i_last,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [K_DWIDTH-1:0] o_data,
    output logic                o_rx_valid,
    output logic                o_busy,
    output logic                o_spi_clk,
    output logic                o_mosi,
    input  logic                i_miso,
    output logic                o_cs_n
);
    localparam int CW = $clog2(K_CLKDIV + 1);
    localparam int BW = (K_DWIDTH > 1) ? $clog2(K_DWIDTH) : 1;
    localparam logic [CW-1:0] HP_TOP = CW'(K_CLKDIV - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(K_DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, TAIL, GAP, CSOFF
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       hp_cnt_q, hp_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [K_DWIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [K_DWIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [K_DWIDTH-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                rx_valid_q, rx_valid_d;
    logic                ready_q, ready_d;
    logic                accept;
    logic                hp_tick;

    assign accept  = i_valid & ready_q;
    assign hp_tick = (hp_cnt_q == HP_TOP);

    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_tick ? '0 : hp_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        data_d     = data_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                hp_cnt_d = '0;
                if (accept) begin
                    state_d   = SETUP;
                    tx_sr_d   = i_data;
                    last_d    = i_last;
                    bit_cnt_d = '0;
                end
            end
            SETUP: begin
                if (hp_tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (hp_tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sr_d = K_DWIDTH'({rx_sr_q, i_miso});
                    end else if (bit_cnt_q == BIT_TOP) begin
                        rx_valid_d = 1'b1;
                        data_d     = rx_sr_q;
                        state_d    = last_q ? TAIL : GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_sr_d   = tx_sr_q << 1;
                    end
                end
            end
            TAIL: begin
                if (hp_tick) state_d = CSOFF;
            end
            CSOFF: begin
                if (hp_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // CSOFF keeps select high for a minimum deselect time
        cs_n_d  = (state_d == IDLE) || (state_d == CSOFF);
        ready_d = (state_d == IDLE) || (state_d == GAP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            hp_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_cnt_q   <= hp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_data     = data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_spi_clk  = sclk_q;
    assign o_mosi     = tx_sr_q[K_DWIDTH-1];
    assign o_cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master with an SPI
// slave model, plus a second instance running at the fastest divider.
module tb_spi_master;
    localparam int DW     = 16;
    localparam int KD     = 2;
    localparam int FRAME  = (2 * DW + 1) * KD;
    localparam int PERIOD = FRAME + 2 * KD + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_rx_valid;
    logic          o_busy;
    logic          o_spi_clk;
    logic          o_mosi;
    logic          i_miso;
    logic          o_cs_n;

    logic [DW-1:0] b_data = '0;
    logic          b_last = 1'b0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [DW-1:0] b_odata;
    logic          b_rxv;
    logic          b_busy;
    logic          b_sclk;
    logic          b_mosi;
    logic          b_cs_n;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    bit            sb_q[$];
    bit            loop = 1'b0;
    logic          miso_r = 1'b0;
    logic          s_prev = 1'b0;
    int            rxv_cnt = 0;
    int            rise_cnt = 0;
    int            cs_rise_cnt = 0;
    logic [DW-1:0] mosi_sh = '0;
    logic          prev_sclk = 1'b0;
    logic          prev_cs = 1'b1;

    assign i_miso = loop ? o_mosi : miso_r;

    spi_master #(.K_DWIDTH(DW), .K_CLKDIV(KD)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_last(i_last),
        .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
        .o_rx_valid(o_rx_valid), .o_busy(o_busy), .o_spi_clk(o_spi_clk),
        .o_mosi(o_mosi), .i_miso(i_miso), .o_cs_n(o_cs_n)
    );

    spi_master #(.K_DWIDTH(DW), .K_CLKDIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_last(b_last),
        .i_valid(b_valid), .o_ready(b_ready), .o_data(b_odata),
        .o_rx_valid(b_rxv), .o_busy(b_busy), .o_spi_clk(b_sclk),
        .o_mosi(b_mosi), .i_miso(b_mosi), .o_cs_n(b_cs_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Slave: presents bits MSB first, advancing after each falling edge
    always @(negedge clk) begin
        if (rst) sb_q.delete();
        else if (!o_spi_clk && s_prev && sb_q.size() > 0)
            void'(sb_q.pop_front());
        s_prev = o_spi_clk;
        miso_r = (sb_q.size() > 0) ? sb_q[0] : 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            rise_cnt = 0;
        end else begin
            if (o_spi_clk && !prev_sclk) begin
                rise_cnt++;
                mosi_sh = {mosi_sh[DW-2:0], o_mosi};
            end
            if (o_cs_n && !prev_cs) cs_rise_cnt++;
            if (o_rx_valid) begin
                rxv_cnt++;
                chk("rx_expected", rx_q.size() > 0, 1);
                if (rx_q.size() > 0) begin
                    chk("rx_data", o_data, rx_q.pop_front());
                    chk("mosi_word", mosi_sh, tx_q.pop_front());
                    chk("rise_count", rise_cnt, DW);
                end
                rise_cnt = 0;
            end
        end
        prev_sclk = o_spi_clk;
        prev_cs = o_cs_n;
    end

    task automatic expect_word(input logic [DW-1:0] w,
                               input logic [DW-1:0] sw);
        tx_q.push_back(w);
        rx_q.push_back(loop ? w : sw);
        for (int i = DW - 1; i >= 0; i--) sb_q.push_back(sw[i]);
    endtask

    task automatic send(input logic [DW-1:0] w, input bit last,
                        input logic [DW-1:0] sw);
        int n = 0;
        @(negedge clk);
        i_data = w;
        i_last = last;
        i_valid = 1'b1;
        while (!o_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", o_ready, 1);
        expect_word(w, sw);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data = DW'($urandom);
        i_last = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(o_ready && !o_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", o_ready && !o_busy, 1);
    endtask

    initial begin
        int n, lo, hi, flen, c0, r, rxv0;
        int bad_cs, bad_ck, bad_rdy, bad_busy, bad_mosi;
        int acc[$];
        logic pv, m0;
        logic [DW-1:0] w, sw, b_word;
        bit last;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", o_cs_n, 1);
        chk("rst_sclk", o_spi_clk, 0);
        chk("rst_mosi", o_mosi, 0);
        chk("rst_data", o_data, 0);
        chk("rst_rxv", o_rx_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", o_ready, 1);

        // Loopback single frame
        loop = 1'b1;
        send(16'hA001, 1'b1, 16'h0000);
        lo = 0; hi = 0; flen = -1; n = 0;
        @(negedge clk);
        while (!o_cs_n && n < 500) begin
            if (o_rx_valid) flen = lo;
            lo++;
            n++;
            @(negedge clk);
        end
        while (!o_ready && n < 1000) begin
            hi++;
            n++;
            @(negedge clk);
        end
        chk("frame_len", flen, FRAME);
        chk("cs_low_cycles", lo, FRAME + KD);
        chk("cs_high_cycles", hi, KD);
        loop = 1'b0;

        // Two-word burst, chip select held between words
        wait_idle();
        c0 = cs_rise_cnt;
        send(16'h1234, 1'b0, 16'h5555);
        send(16'hCAFE, 1'b1, 16'hCAFE);
        chk("burst_cs_held", cs_rise_cnt, c0);
        wait_idle();
        chk("burst_cs_rise", cs_rise_cnt, c0 + 1);

        // Randomized bursts with random idle spacing
        for (int i = 0; i < 24; i++) begin
            last = ($urandom_range(0, 3) == 0) || (i == 23);
            send(DW'($urandom), last, DW'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();

        // Valid held high: one acceptance per ready window
        i_data = DW'($urandom);
        i_last = 1'b1;
        i_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            if (o_ready) begin
                acc.push_back(c);
                expect_word(i_data, DW'($urandom));
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("hold_acc_count", acc.size(), (200 - 1) / PERIOD + 1);
        for (int i = 1; i < acc.size(); i++)
            chk("hold_interval", acc[i] - acc[i-1], PERIOD);
        wait_idle();

        // Long GAP with no request
        send(DW'($urandom), 1'b0, DW'($urandom));
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        bad_cs = 0; bad_ck = 0; bad_rdy = 0; bad_busy = 0; bad_mosi = 0;
        m0 = o_mosi;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (o_cs_n) bad_cs++;
            if (o_spi_clk) bad_ck++;
            if (!o_ready) bad_rdy++;
            if (!o_busy) bad_busy++;
            if (o_mosi !== m0) bad_mosi++;
        end
        chk("gap_cs_low", bad_cs, 0);
        chk("gap_sclk_low", bad_ck, 0);
        chk("gap_ready", bad_rdy, 0);
        chk("gap_busy", bad_busy, 0);
        chk("gap_mosi_held", bad_mosi, 0);
        send(DW'($urandom), 1'b1, DW'($urandom));
        wait_idle();

        // Reset mid-frame after the 8th rising edge
        send(DW'($urandom), 1'b1, DW'($urandom));
        r = 0; pv = 1'b0; n = 0;
        while (r < 8 && n < 500) begin
            @(negedge clk);
            if (o_spi_clk && !pv) r++;
            pv = o_spi_clk;
            n++;
        end
        chk("abort_reach8", r, 8);
        rxv0 = rxv_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_cs_n", o_cs_n, 1);
        chk("abort_sclk", o_spi_clk, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_rxv", o_rx_valid, 0);
        @(posedge clk);
        #1;
        chk("abort_ready", o_ready, 1);
        repeat (80) @(posedge clk);
        chk("abort_no_rxv", rxv_cnt, rxv0);
        send(DW'($urandom), 1'b1, DW'($urandom));
        wait_idle();
        chk("post_abort_rxv", rxv_cnt, rxv0 + 1);

        // Fastest divider instance, loopback
        b_word = DW'($urandom);
        @(negedge clk);
        b_data = b_word;
        b_last = 1'b1;
        b_valid = 1'b1;
        n = 0;
        while (!b_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("k1_ready", b_ready, 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        lo = 0; hi = 0; r = 0; pv = 1'b0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (b_sclk && !pv) r++;
            if (b_sclk) hi++;
            pv = b_sclk;
            if (!b_rxv) lo++;
        end while (!b_rxv && n < 200);
        chk("k1_frame_len", lo, 2 * DW + 1);
        chk("k1_rises", r, DW);
        chk("k1_high_cycles", hi, DW);
        chk("k1_data", b_odata, b_word);

        repeat (10) @(negedge clk);
        chk("sb_drain", tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
